// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter and pending-write scoreboard for the 8 x 16-bit register
// file. The ALU and load unit share one write port through valid/ready
// handshakes with round-robin fairness. The write port is driven from a
// registered output stage. A busy bitmap tracks every destination that has
// been issued but not yet written back.
module regfile_write_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              rf_hold,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic [NREG-1:0]   busy_vec
);

    // Source that won the most recent grant; the other side wins the next contest.
    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

    grant_t              r_last_grant;
    logic                r_write_en;
    logic [ADDR_W-1:0]   r_write_addr;
    logic [DATA_W-1:0]   r_write_data;
    logic [NREG-1:0]     r_busy;

    logic                w_enable;
    logic                w_alu_win;
    logic                w_mem_win;
    logic [NREG-1:0]     w_busy_next;

    // Grants are blocked during reset and while the register file is held.
    assign w_enable  = rst_n && !rf_hold;

    // Round-robin grant: an uncontested request always wins; a contest goes
    // to the source that did not win last time. Only valids and the history
    // bit feed the decision, never the requester's address or data.
    assign w_alu_win = w_enable && alu_valid && (!mem_valid || (r_last_grant == GRANT_MEM));
    assign w_mem_win = w_enable && mem_valid && (!alu_valid || (r_last_grant == GRANT_ALU));

    assign alu_ready = w_alu_win;
    assign mem_ready = w_mem_win;

    // Next scoreboard state: a new issue to a register wins over a same-cycle
    // retirement, because the issue names a newer, still-pending writer.
    always_comb begin
        // NOTE: default assignment first so no path leaves the vector unassigned (no latch).
        w_busy_next = r_busy;
        for (int i = 0; i < NREG; i++) begin
            if (issue_valid && (issue_addr == ADDR_W'(i))) begin
                w_busy_next[i] = 1'b1;
            end else if (r_write_en && (r_write_addr == ADDR_W'(i))) begin
                w_busy_next[i] = 1'b0;
            end
        end
    end

    // Round-robin history: records the winner of every grant, untouched when idle or held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Reset looks as if MEM won last, so the ALU takes the first contest.
            r_last_grant <= GRANT_MEM;
        end else if (w_alu_win) begin
            // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
            r_last_grant <= GRANT_ALU;
        end else if (w_mem_win) begin
            r_last_grant <= GRANT_MEM;
        end
    end

    // Output stage: load the winner's write; on idle cycles pulse enable low and keep addr/data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write_en   <= 1'b0;
            r_write_addr <= '0;
            r_write_data <= '0;
        end else begin
            r_write_en <= w_alu_win || w_mem_win;
            if (w_alu_win) begin
                r_write_addr <= alu_addr;
                r_write_data <= alu_data;
            end else if (w_mem_win) begin
                r_write_addr <= mem_addr;
                r_write_data <= mem_data;
            end
        end
    end

    // Pending-write scoreboard; cleared on reset since any in-flight write is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this is a flop vector, not a RAM, so an async clear is legal and cheap.
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign rf_write_en   = r_write_en;
    assign rf_write_addr = r_write_addr;
    assign rf_write_data = r_write_data;
    assign busy_vec      = r_busy;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter. Inputs change just
// after the rising edge; outputs are sampled on the falling edge.
module tb_regfile_write_arbiter;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREG   = 8;

    logic              clk;
    logic              rst_n;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              rf_hold;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_addr;
    logic              rf_write_en;
    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_write_data;
    logic [NREG-1:0]   busy_vec;

    int n_cmp = 0;
    int n_err = 0;

    regfile_write_arbiter #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NREG  (NREG)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid    (alu_valid),
        .alu_addr     (alu_addr),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .mem_valid    (mem_valid),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .rf_hold      (rf_hold),
        .issue_valid  (issue_valid),
        .issue_addr   (issue_addr),
        .rf_write_en  (rf_write_en),
        .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data),
        .busy_vec     (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for the falling edge of the current cycle.
    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check_write(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        check({tag, ".en"},   32'(rf_write_en),   32'd1);
        check({tag, ".addr"}, 32'(rf_write_addr), 32'(a));
        check({tag, ".data"}, 32'(rf_write_data), 32'(d));
    endtask

    logic exp_alu_first [4];
    logic prev_alu;

    initial begin
        exp_alu_first = '{1'b1, 1'b0, 1'b1, 1'b0};

        // Reset with an ALU request already present: readies must stay low.
        rst_n       = 1'b0;
        alu_valid   = 1'b1;
        alu_addr    = 3'd3;
        alu_data    = 16'h1357;
        mem_valid   = 1'b1;
        mem_addr    = 3'd2;
        mem_data    = 16'h2468;
        rf_hold     = 1'b0;
        issue_valid = 1'b0;
        issue_addr  = '0;
        #12;
        check("rst.alu_ready", 32'(alu_ready),     32'd0);
        check("rst.mem_ready", 32'(mem_ready),     32'd0);
        check("rst.en",        32'(rf_write_en),   32'd0);
        check("rst.addr",      32'(rf_write_addr), 32'd0);
        check("rst.data",      32'(rf_write_data), 32'd0);
        check("rst.busy",      32'(busy_vec),      32'd0);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        #1 rst_n = 1'b1;
        step();

        // Single ALU write: grant in cycle 1, write visible in cycle 2, gone in cycle 3.
        alu_valid = 1'b1; alu_addr = 3'd3; alu_data = 16'hA5A5;
        sample();
        check("t1.alu_ready", 32'(alu_ready), 32'd1);
        check("t1.mem_ready", 32'(mem_ready), 32'd0);
        step();
        alu_valid = 1'b0;
        sample();
        check_write("t1.c2", 3'd3, 16'hA5A5);
        step();
        sample();
        check("t1.c3.en",   32'(rf_write_en),   32'd0);
        check("t1.c3.addr", 32'(rf_write_addr), 32'd3);
        step();

        // Single MEM write; leaves MEM as last winner so the ALU takes the next contest.
        mem_valid = 1'b1; mem_addr = 3'd7; mem_data = 16'h7777;
        sample();
        check("m1.mem_ready", 32'(mem_ready), 32'd1);
        check("m1.alu_ready", 32'(alu_ready), 32'd0);
        step();
        mem_valid = 1'b0;
        sample();
        check_write("m1.out", 3'd7, 16'h7777);
        step();

        // Continuous contention: grants alternate ALU, MEM, ALU, MEM with back-to-back writes.
        alu_valid = 1'b1; alu_addr = 3'd1; alu_data = 16'h1111;
        mem_valid = 1'b1; mem_addr = 3'd2; mem_data = 16'h2222;
        prev_alu = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sample();
            check($sformatf("rr%0d.alu_ready", k), 32'(alu_ready), 32'(exp_alu_first[k]));
            check($sformatf("rr%0d.mem_ready", k), 32'(mem_ready), 32'(!exp_alu_first[k]));
            if (k > 0) begin
                if (prev_alu) check_write($sformatf("rr%0d.out", k), 3'd1, 16'h1111);
                else          check_write($sformatf("rr%0d.out", k), 3'd2, 16'h2222);
            end
            prev_alu = exp_alu_first[k];
            step();
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        sample();
        check_write("rr4.out", 3'd2, 16'h2222);
        step();

        // Hold blocks both sources; history still says MEM, so ALU wins after release.
        rf_hold = 1'b1;
        alu_valid = 1'b1;
        mem_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sample();
            check($sformatf("hold%0d.alu_ready", k), 32'(alu_ready),   32'd0);
            check($sformatf("hold%0d.mem_ready", k), 32'(mem_ready),   32'd0);
            check($sformatf("hold%0d.en", k),        32'(rf_write_en), 32'd0);
            step();
        end
        rf_hold = 1'b0;
        sample();
        check("rel.alu_ready", 32'(alu_ready), 32'd1);
        check("rel.mem_ready", 32'(mem_ready), 32'd0);
        step();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        sample();
        check_write("rel.out", 3'd1, 16'h1111);
        step();

        // Scoreboard: issue r5 in cycle 1, MEM writes r5 granted in cycle 4, busy clears by cycle 6.
        issue_valid = 1'b1; issue_addr = 3'd5;
        sample();
        check("sb.c1.busy", 32'(busy_vec), 32'h00);
        step();
        issue_valid = 1'b0;
        sample();
        check("sb.c2.busy", 32'(busy_vec), 32'h20);
        step();
        sample();
        step();
        mem_valid = 1'b1; mem_addr = 3'd5; mem_data = 16'h5555;
        sample();
        check("sb.c4.mem_ready", 32'(mem_ready), 32'd1);
        step();
        mem_valid = 1'b0;
        sample();
        check_write("sb.c5", 3'd5, 16'h5555);
        check("sb.c5.busy", 32'(busy_vec), 32'h20);
        step();
        sample();
        check("sb.c6.busy", 32'(busy_vec), 32'h00);
        step();

        // Simultaneous set and clear of r6: the new issue keeps the bit set.
        issue_valid = 1'b1; issue_addr = 3'd6;
        sample();
        step();
        issue_valid = 1'b0;
        mem_valid = 1'b1; mem_addr = 3'd6; mem_data = 16'h6060;
        sample();
        check("sc.a1.busy",      32'(busy_vec),  32'h40);
        check("sc.a1.mem_ready", 32'(mem_ready), 32'd1);
        step();
        mem_valid = 1'b0;
        issue_valid = 1'b1; issue_addr = 3'd6;
        sample();
        check_write("sc.a2", 3'd6, 16'h6060);
        step();
        issue_valid = 1'b0;
        sample();
        check("sc.a3.busy", 32'(busy_vec),    32'h40);
        check("sc.a3.en",   32'(rf_write_en), 32'd0);
        step();

        // Build busy=0x0C with a write in flight, then reset asynchronously mid-cycle.
        issue_valid = 1'b1; issue_addr = 3'd2;
        alu_valid = 1'b1; alu_addr = 3'd6; alu_data = 16'h6666;
        sample();
        check("mr.c1.alu_ready", 32'(alu_ready), 32'd1);
        step();
        issue_addr = 3'd3;
        alu_valid = 1'b0;
        mem_valid = 1'b1; mem_addr = 3'd0; mem_data = 16'h0ABC;
        sample();
        check_write("mr.c2", 3'd6, 16'h6666);
        check("mr.c2.busy",      32'(busy_vec),  32'h44);
        check("mr.c2.mem_ready", 32'(mem_ready), 32'd1);
        step();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_addr = 3'd4; alu_data = 16'h4444;
        mem_valid = 1'b1; mem_addr = 3'd1; mem_data = 16'h1234;
        sample();
        check_write("mr.c3", 3'd0, 16'h0ABC);
        check("mr.c3.busy", 32'(busy_vec), 32'h0C);
        #2 rst_n = 1'b0;
        #1;
        check("mr.rst.en",        32'(rf_write_en),   32'd0);
        check("mr.rst.busy",      32'(busy_vec),      32'h00);
        check("mr.rst.alu_ready", 32'(alu_ready),     32'd0);
        check("mr.rst.mem_ready", 32'(mem_ready),     32'd0);
        check("mr.rst.addr",      32'(rf_write_addr), 32'd0);
        check("mr.rst.data",      32'(rf_write_data), 32'd0);
        step();
        check("mr.rst.edge.en", 32'(rf_write_en), 32'd0);
        rst_n = 1'b1;
        sample();
        check("post.alu_ready", 32'(alu_ready), 32'd1);
        check("post.mem_ready", 32'(mem_ready), 32'd0);
        step();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        sample();
        check_write("post.out", 3'd4, 16'h4444);
        check("post.busy", 32'(busy_vec), 32'h00);
        step();
        sample();
        check("post.idle.en", 32'(rf_write_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
